prime_checker: RTL and testbench

- Consumer end of the prime-number stream: receives candidate numbers over a valid/ready handshake and decides primality by sequential trial division.
- Returns one verdict per candidate over an output valid/ready handshake, and keeps a running count of primes confirmed.
- Sits downstream of the prime generator and checks its output or any external number source.

---
 rtl/prime_pkg.sv | 18 +
 rtl/prime_trial_step.sv | 47 ++++
 rtl/prime_checker.sv | 101 ++++++++++
 tb/tb_prime_checker.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/prime_pkg.sv
// prime_pkg: shared definitions for the prime checker slice.
//   DEFAULT_WIDTH : default candidate / divisor / count width
//   state_t       : FSM encoding (IDLE, CHECK, DONE)
//   COUNT_MAX     : saturation value of the prime counter at the default width
// Optional feature macro used by this slice: PRIME_ODD_SKIP_EN
package prime_pkg;

  localparam int DEFAULT_WIDTH = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [DEFAULT_WIDTH-1:0] COUNT_MAX = '1;

endpackage

// File: rtl/prime_trial_step.sv
// prime_trial_step: one combinational trial-division step.
//   cand     : candidate under test
//   div      : current trial divisor (always >= 2 when used)
//   is_done  : the trial ends the check this cycle
//   is_prime : verdict when is_done (1 = prime)
//   next_div : divisor to use on the next trial
// PRIME_ODD_SKIP_EN: when defined, the divisor steps 2 -> 3 -> 5 -> 7 ...
//   (even divisors above 2 are skipped); otherwise it steps by 1.
module prime_trial_step #(
  parameter int WIDTH = prime_pkg::DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] cand,
  input  logic [WIDTH-1:0] div,
  output logic             is_done,
  output logic             is_prime,
  output logic [WIDTH-1:0] next_div
);

  logic [2*WIDTH-1:0] div_sq;
  logic [WIDTH-1:0]   rem;
  logic               sq_over;

  // Full-width square so the compare never suffers truncation.
  assign div_sq  = {{WIDTH{1'b0}}, div} * {{WIDTH{1'b0}}, div};
  assign sq_over = div_sq > {{WIDTH{1'b0}}, cand};
  assign rem     = cand % div;

  always_comb begin
    is_done  = 1'b0;
    is_prime = 1'b0;
    // Square test has priority: no divisor up to sqrt(cand) divided it.
    if (sq_over) begin
      is_done  = 1'b1;
      is_prime = 1'b1;
    end else if (rem == '0) begin
      is_done  = 1'b1;
      is_prime = 1'b0;
    end
  end

`ifdef PRIME_ODD_SKIP_EN
  assign next_div = (div == WIDTH'(2)) ? WIDTH'(3) : div + WIDTH'(2);
`else
  assign next_div = div + WIDTH'(1);
`endif

endmodule

// File: rtl/prime_checker.sv
// prime_checker: primality checker by sequential trial division.
//   clk, rst     : clock, synchronous active-high reset
//   in_valid     : candidate present on in_number
//   in_number    : candidate (unsigned)
//   in_ready     : high only in IDLE
//   out_valid    : verdict available (DONE)
//   out_ready    : downstream accepts the verdict
//   out_number   : candidate the verdict belongs to
//   out_is_prime : 1 = prime
//   prime_count  : primes delivered since reset, saturating at all-ones
//   state        : current FSM state (debug visibility)
// Optional feature macro: PRIME_ODD_SKIP_EN (odd-only divisor stepping,
//   implemented inside prime_trial_step).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready=0 ignores in_valid (the source holds it); out_valid
// with out_ready=0 holds out_number/out_is_prime stable indefinitely.
module prime_checker
  import prime_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_number,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_number,
  output logic             out_is_prime,
  output logic [WIDTH-1:0] prime_count,
  output state_t           state
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] div;
  logic             step_done;
  logic             step_prime;
  logic [WIDTH-1:0] step_next_div;

  prime_trial_step #(.WIDTH(WIDTH)) u_step (
    .cand     (cand),
    .div      (div),
    .is_done  (step_done),
    .is_prime (step_prime),
    .next_div (step_next_div)
  );

  // Handshake flags decode straight from the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cand         <= '0;
      div          <= WIDTH'(2);
      out_number   <= '0;
      out_is_prime <= 1'b0;
      prime_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cand       <= in_number;
            div        <= WIDTH'(2);
            out_number <= in_number;
            // 0 and 1 are not prime and skip the trial loop entirely.
            if (in_number < WIDTH'(2)) begin
              out_is_prime <= 1'b0;
              state        <= DONE;
            end else begin
              state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (step_done) begin
            out_is_prime <= step_prime;
            state        <= DONE;
          end else begin
            div <= step_next_div;
          end
        end
        DONE: begin
          if (out_ready) begin
            if (out_is_prime && (prime_count != CNT_MAX)) begin
              prime_count <= prime_count + WIDTH'(1);
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prime_checker.sv
// tb_prime_checker: self-checking bench for prime_checker.
module tb_prime_checker;
  import prime_pkg::*;

  localparam int W = DEFAULT_WIDTH;
  localparam int CMAX = (1 << W) - 1;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_number;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_number;
  logic         out_is_prime;
  logic [W-1:0] prime_count;
  state_t       state;

  always #5 clk = ~clk;

  prime_checker #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_number    (in_number),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_number   (out_number),
    .out_is_prime (out_is_prime),
    .prime_count  (prime_count),
    .state        (state)
  );

  // ---------------- scoreboard ----------------
  logic [W:0] exp_q[$];  // {is_prime, number}
  int total  = 0;
  int passed = 0;
  int exp_count = 0;

  typedef struct {
    int num;
    int prime;
    int lat;
    int lat_skip;
  } vec_t;
  vec_t vecs[11];

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic int ref_prime(input int n);
    if (n < 2) return 0;
    for (int d = 2; d * d <= n; d++) if (n % d == 0) return 0;
    return 1;
  endfunction

  // Acceptance edge counts as 1, plus one per CHECK cycle.
  function automatic int ref_lat(input int n);
    int d;
    int l;
    if (n < 2) return 1;
    d = 2;
    l = 1;
    while (l < 1000) begin
      l++;
      if (d * d > n) return l;
      if (n % d == 0) return l;
`ifdef PRIME_ODD_SKIP_EN
      d = (d == 2) ? 3 : d + 2;
`else
      d = d + 1;
`endif
    end
    return l;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_count = 0;
    exp_q.delete();
  endtask

  // Send one candidate, wait for the verdict, optionally stall out_ready,
  // then complete the output handshake and check everything.
  task automatic run_one(input int n, input int exp_prime, input int exp_lat,
                         input int stall);
    int guard;
    int lat;
    logic [W:0] e;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check($sformatf("in_ready_timeout n=%0d", n), 0, 1);
      return;
    end
    in_valid  = 1'b1;
    in_number = W'(n);
    @(posedge clk);
    exp_q.push_back({exp_prime[0], W'(n)});
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("latency n=%0d", n), lat, exp_lat);
    if (!out_valid) return;
    for (int i = 0; i < stall; i++) begin
      check($sformatf("stall_valid n=%0d", n), int'(out_valid), 1);
      check($sformatf("stall_number n=%0d", n), int'(out_number), n);
      check($sformatf("stall_prime n=%0d", n), int'(out_is_prime), exp_prime);
      check($sformatf("stall_in_ready n=%0d", n), int'(in_ready), 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    if (exp_q.size() == 0) begin
      check("scoreboard_underflow", 0, 1);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("out_number n=%0d", n), int'(out_number), int'(e[W-1:0]));
      check($sformatf("out_is_prime n=%0d", n), int'(out_is_prime), int'(e[W]));
    end
    if (exp_prime != 0 && exp_count < CMAX) exp_count++;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check($sformatf("prime_count after n=%0d", n), int'(prime_count), exp_count);
    check($sformatf("back_to_idle n=%0d", n), int'(out_valid), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int seen;
    rst = 1'b1;
    in_valid = 1'b0;
    in_number = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", int'(in_ready), 1);
    check("reset out_valid", int'(out_valid), 0);
    check("reset out_number", int'(out_number), 0);
    check("reset out_is_prime", int'(out_is_prime), 0);
    check("reset prime_count", int'(prime_count), 0);
    check("reset state", int'(state), int'(IDLE));
    rst = 1'b0;

    // Reset while checking 97: verdict discarded.
    @(negedge clk);
    in_valid  = 1'b1;
    in_number = W'(97);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid-check state", int'(state), int'(CHECK));
    do_reset();
    check("post-reset in_ready", int'(in_ready), 1);
    check("post-reset out_valid", int'(out_valid), 0);
    check("post-reset prime_count", int'(prime_count), 0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("no verdict for discarded 97", seen, 0);

    // Table-driven vectors.
    vecs[0]  = '{0,    0, 1,  1};
    vecs[1]  = '{1,    0, 1,  1};
    vecs[2]  = '{2,    1, 2,  2};
    vecs[3]  = '{3,    1, 2,  2};
    vecs[4]  = '{4,    0, 2,  2};
    vecs[5]  = '{9,    0, 3,  3};
    vecs[6]  = '{7,    1, 3,  3};
    vecs[7]  = '{25,   0, 5,  4};
    vecs[8]  = '{97,   1, 10, 7};
    vecs[9]  = '{91,   0, 7,  5};
    vecs[10] = '{2047, 0, 23, 13};
    for (int i = 0; i < 11; i++) begin
`ifdef PRIME_ODD_SKIP_EN
      run_one(vecs[i].num, vecs[i].prime, vecs[i].lat_skip, 0);
`else
      run_one(vecs[i].num, vecs[i].prime, vecs[i].lat, 0);
`endif
      if (i == 4) check("prime_count after 0..4", int'(prime_count), 2);
    end

    // 25 with a 5-cycle output stall.
    check("in_ready before stall test", int'(in_ready), 1);
`ifdef PRIME_ODD_SKIP_EN
    run_one(25, 0, 4, 5);
`else
    run_one(25, 0, 5, 5);
`endif

    // Sweep 0..35 from a clean count.
    do_reset();
    for (int n = 0; n <= 35; n++) run_one(n, ref_prime(n), ref_lat(n), 0);
    check("sweep prime_count", int'(prime_count), 11);

    // Saturation: drive the counter to all-ones, then one more prime.
    do_reset();
    while (exp_count < CMAX) run_one(2, 1, 2, 0);
    check("count at max", int'(prime_count), CMAX);
    run_one(3, 1, 2, 0);
    check("count saturated", int'(prime_count), CMAX);
    run_one(5, 1, 3, 0);
    check("count still saturated", int'(prime_count), CMAX);

    // ---------------- final report ----------------
    check("scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
